life_ctrl: RTL and testbench

Sequencing controller for the 16x16 Game-of-Life `datapath`. It turns host commands (load, start, stop, single-step) into the datapath's `reset`/`run` controls and paces generations with a programmable period. It watches `grid_evolve` to count generations, detect a still life, and halt at a generation limit. It sits between the top-level command/switch logic and the datapath instance.

---
 rtl/life_pkg.sv | 62 ++++++
 rtl/life_tick_gen.sv | 41 ++++
 rtl/life_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_life_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared types and constants for the Game-of-Life sequencing controller.
//   - ctrl_state_t : controller FSM encoding (also exported on the debug port)
//   - cmd_t        : the single host command that wins in a given cycle
//   - GRID_W/ROW_W : 16x16 grid geometry
//   - PRIO_*       : command priority ranks (higher rank wins)
//   - cmd_decode   : picks the highest-priority asserted command
// ---------------------------------------------------------------------------
package life_pkg;

    localparam int ROW_W  = 16;
    localparam int GRID_W = ROW_W * ROW_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_WAIT = 3'd4,
        ST_HALT = 3'd5
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_STOP  = 3'd2,
        CMD_STEP  = 3'd3,
        CMD_START = 3'd4
    } cmd_t;

    localparam int PRIO_LOAD  = 3;
    localparam int PRIO_STOP  = 2;
    localparam int PRIO_STEP  = 1;
    localparam int PRIO_START = 0;

    // Only one command survives per cycle; the others are dropped.
    function automatic cmd_t cmd_decode(input logic i_load, input logic i_stop,
                                        input logic i_step, input logic i_start);
        cmd_t w_cmd;
        int   w_best;
        w_cmd  = CMD_NONE;
        w_best = -1;
        if (i_start && (PRIO_START > w_best)) begin
            w_cmd  = CMD_START;
            w_best = PRIO_START;
        end
        if (i_step && (PRIO_STEP > w_best)) begin
            w_cmd  = CMD_STEP;
            w_best = PRIO_STEP;
        end
        if (i_stop && (PRIO_STOP > w_best)) begin
            w_cmd  = CMD_STOP;
            w_best = PRIO_STOP;
        end
        if (i_load && (PRIO_LOAD > w_best)) begin
            w_cmd  = CMD_LOAD;
        end
        return w_cmd;
    endfunction

endpackage

// File: rtl/life_tick_gen.sv
// ---------------------------------------------------------------------------
// life_tick_gen
// Generation-period divider. Counts 0..max(period,1)-1 while enabled and
// flags the terminal count combinationally so the FSM can act on it in the
// same cycle.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset
//   i_clr    : synchronous clear of the count (dominates enable)
//   i_en     : count enable
//   i_period : cycles per tick, 0 behaves as 1
//   o_tc     : terminal count reached this cycle
// ---------------------------------------------------------------------------
module life_tick_gen (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_period,
    output logic       o_tc
);

    logic [7:0] r_cnt;
    logic [7:0] w_last;

    assign w_last = (i_period == 8'd0) ? 8'd0 : (i_period - 8'd1);

    // ">=" rather than "==": if period shrinks below the running count the
    // tick still fires on the current count instead of wrapping through 255.
    assign o_tc = i_en && !i_clr && (r_cnt >= w_last);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= o_tc ? 8'd0 : (r_cnt + 8'd1);
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// ---------------------------------------------------------------------------
// life_ctrl
// Sequencing controller for the 16x16 Game-of-Life datapath. Converts host
// commands into datapath reset/run pulses, paces generations, counts them,
// detects still lifes and halts at a generation limit.
//   clk, reset        : clock, synchronous active-low reset
//   cmd_load/start/
//   cmd_stop/step     : single-cycle host command pulses
//   period            : clk cycles per generation while running (0 -> 1)
//   max_gen           : generation limit, 0 = unlimited
//   grid_evolve       : current grid from the datapath
//   dp_reset, dp_run  : registered datapath controls
//   gen_count         : generations since last load (saturating)
//   stable            : last sampled grid equals the previous one
//   done              : generation limit reached
//   busy              : in LOAD, RUN, STEP or WAIT
//   state             : FSM state for debug
// ---------------------------------------------------------------------------
module life_ctrl
    import life_pkg::*;
#(
    parameter int LOAD_CYCLES = 2,
    parameter int DP_LAT      = 1,
    parameter int GEN_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_load,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_step,
    input  logic [7:0]        period,
    input  logic [GEN_W-1:0]  max_gen,
    input  logic [GRID_W-1:0] grid_evolve,
    output logic              dp_reset,
    output logic              dp_run,
    output logic [GEN_W-1:0]  gen_count,
    output logic              stable,
    output logic              done,
    output logic              busy,
    output logic [2:0]        state
);

    localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int WC_W = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;
    localparam logic [LC_W-1:0] LC_LAST   = LC_W'(LOAD_CYCLES - 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(DP_LAT);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_next;
    cmd_t              w_cmd;
    logic [LC_W-1:0]   r_load_cnt;
    logic [WC_W-1:0]   r_wait_cnt;
    logic              r_from_step;
    logic              r_pend_load;
    logic              r_pend_stop;
    logic [GEN_W-1:0]  r_gen;
    logic              r_stable;
    logic              r_done;
    logic [GRID_W-1:0] r_prev;
    logic              r_dp_reset;
    logic              r_dp_run;

    logic              w_tc;
    logic              w_sample;
    logic [GEN_W-1:0]  w_gen_inc;
    logic              w_is_stable;
    logic              w_hit_limit;
    logic              w_load_req;
    logic              w_stop_req;

    assign w_cmd = cmd_decode(cmd_load, cmd_stop, cmd_step, cmd_start);

    life_tick_gen u_tick (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_clr    (r_state != ST_RUN),
        .i_en     (r_state == ST_RUN),
        .i_period (period),
        .o_tc     (w_tc)
    );

    // The dp_run pulse lands in the first WAIT cycle (index 0); the new
    // generation is visible DP_LAT cycles later, at the last WAIT cycle.
    assign w_sample    = (r_state == ST_WAIT) && (r_wait_cnt == WAIT_LAST);
    assign w_gen_inc   = (&r_gen) ? r_gen : (r_gen + 1'b1);
    assign w_is_stable = (grid_evolve == r_prev);
    assign w_hit_limit = (max_gen != '0) && (w_gen_inc == max_gen);

    // Stop/load seen earlier in WAIT are held until the sample completes.
    assign w_load_req  = r_pend_load || cmd_load;
    assign w_stop_req  = r_pend_stop || cmd_stop;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                case (w_cmd)
                    CMD_LOAD:  w_state_next = ST_LOAD;
                    CMD_STEP:  w_state_next = ST_STEP;
                    CMD_START: w_state_next = ST_RUN;
                    default:   w_state_next = ST_IDLE;
                endcase
            end
            ST_LOAD: begin
                if (w_cmd == CMD_LOAD) begin
                    w_state_next = ST_LOAD;
                end else if (r_load_cnt == LC_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_cmd == CMD_LOAD) begin
                    w_state_next = ST_LOAD;
                end else if (w_cmd == CMD_STOP) begin
                    w_state_next = ST_IDLE;
                end else if (w_tc) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_STEP: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_sample) begin
                    if (w_load_req) begin
                        w_state_next = ST_LOAD;
                    end else if (w_stop_req) begin
                        w_state_next = ST_IDLE;
                    end else if (w_is_stable || w_hit_limit) begin
                        w_state_next = ST_HALT;
                    end else if (r_from_step) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                if (w_cmd == CMD_LOAD) begin
                    w_state_next = ST_LOAD;
                end else if (w_cmd == CMD_STOP) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_load_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_from_step <= 1'b0;
            r_pend_load <= 1'b0;
            r_pend_stop <= 1'b0;
            r_dp_reset  <= 1'b0;
            r_dp_run    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Restarting LOAD or leaving it returns the count to zero.
            if ((r_state == ST_LOAD) && (w_state_next == ST_LOAD) && (w_cmd != CMD_LOAD)) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end else begin
                r_load_cnt <= '0;
            end

            if ((r_state == ST_WAIT) && !w_sample) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (r_state == ST_STEP) begin
                r_from_step <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_from_step <= 1'b0;
            end

            r_pend_load <= (r_state == ST_WAIT) && !w_sample && w_load_req;
            r_pend_stop <= (r_state == ST_WAIT) && !w_sample && w_stop_req;

            // Registered controls: dp_reset spans the LOAD state, dp_run is
            // issued on the edge that leaves RUN (terminal tick) or STEP.
            r_dp_reset <= (w_state_next == ST_LOAD);
            r_dp_run   <= ((r_state == ST_RUN) && (w_state_next == ST_WAIT))
                          || (r_state == ST_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_done   <= 1'b0;
            r_prev   <= '0;
        end else if (r_state == ST_LOAD) begin
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_done   <= 1'b0;
            r_prev   <= '0;
        end else if (w_sample) begin
            r_gen    <= w_gen_inc;
            r_stable <= w_is_stable;
            r_prev   <= grid_evolve;
            r_done   <= w_hit_limit && (w_state_next == ST_HALT);
        end else if ((r_state == ST_HALT) && (w_cmd == CMD_STOP)) begin
            r_done   <= 1'b0;
        end
    end

    assign dp_reset  = r_dp_reset;
    assign dp_run    = r_dp_run;
    assign gen_count = r_gen;
    assign stable    = r_stable;
    assign done      = r_done;
    assign state     = r_state;
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_RUN)
                       || (r_state == ST_STEP) || (r_state == ST_WAIT);

endmodule

// File: tb/tb_life_ctrl.sv
// ---------------------------------------------------------------------------
// tb_life_ctrl
// Directed bench for life_ctrl with a small behavioural Game-of-Life
// datapath (loads on dp_reset, advances one generation per dp_run cycle,
// result visible the next cycle).
// ---------------------------------------------------------------------------
module tb_life_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_load, cmd_start, cmd_stop, cmd_step;
    logic [7:0]   period;
    logic [15:0]  max_gen;
    logic [255:0] grid = '0;
    logic [255:0] init_state;
    logic         dp_reset, dp_run, stable, done, busy;
    logic [15:0]  gen_count;
    logic [2:0]   state;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2,
                           S_WAIT = 3'd4, S_HALT = 3'd5;
    localparam logic [255:0] BLINKER = 256'h0000e00000;
    localparam logic [255:0] BLOCK   = (256'h3 << 68) | (256'h3 << 84);

    always #5 clk = ~clk;

    life_ctrl #(.LOAD_CYCLES(2), .DP_LAT(1), .GEN_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_load    (cmd_load),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .cmd_step    (cmd_step),
        .period      (period),
        .max_gen     (max_gen),
        .grid_evolve (grid),
        .dp_reset    (dp_reset),
        .dp_run      (dp_run),
        .gen_count   (gen_count),
        .stable      (stable),
        .done        (done),
        .busy        (busy),
        .state       (state)
    );

    function automatic logic [255:0] life_next(input logic [255:0] g);
        logic [255:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
                            cnt += int'(g[rr*16+cc]);
                    end
                end
                n[r*16+c] = g[r*16+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (dp_reset)    grid <= init_state;
        else if (dp_run) grid <= life_next(grid);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive one command pulse for exactly one rising edge.
    task automatic pulse(input logic ld, input logic st, input logic sp, input logic sr);
        cmd_load = ld; cmd_stop = st; cmd_step = sp; cmd_start = sr;
        @(negedge clk);
        cmd_load = 0; cmd_stop = 0; cmd_step = 0; cmd_start = 0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
        int n = 0;
        while (state !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic do_load(input logic [255:0] pat);
        init_state = pat;
        pulse(1, 0, 0, 0);
        wait_state(S_IDLE, 10, "load_idle");
    endtask

    initial begin
        int ndp, np, cyc;
        int t[5];

        reset = 0; cmd_load = 0; cmd_start = 0; cmd_stop = 0; cmd_step = 0;
        period = 8'd4; max_gen = 16'd0; init_state = BLINKER;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_state", state, S_IDLE);
        chk("rst_dp_reset", dp_reset, 0);
        chk("rst_dp_run", dp_run, 0);
        chk("rst_gen", gen_count, 0);
        chk("rst_stable", stable, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 1;
        @(negedge clk);

        // Load: dp_reset high for exactly two cycles
        init_state = BLINKER;
        pulse(1, 0, 0, 0);
        chk("load_state", state, S_LOAD);
        chk("load_busy", busy, 1);
        ndp = 0;
        for (int i = 0; i < 6; i++) begin
            if (dp_reset) ndp++;
            @(negedge clk);
        end
        chk("load_len", ndp, 2);
        chk("load_idle", state, S_IDLE);
        chk("load_gen", gen_count, 0);
        chk("load_stable", stable, 0);

        // Blinker free-run, period 4: pulses 6 cycles apart
        period = 8'd4; max_gen = 16'd0;
        pulse(0, 0, 0, 1);
        chk("run_state", state, S_RUN);
        np = 0; cyc = 0;
        for (int i = 0; i < 80 && np < 5; i++) begin
            @(negedge clk);
            cyc++;
            if (dp_run) begin
                t[np] = cyc;
                np++;
            end
        end
        chk("run_pulses", np, 5);
        chk("run_first", t[0], 4);
        for (int i = 1; i < 5; i++) chk("run_spacing", t[i] - t[i-1], 6);
        repeat (2) @(negedge clk);
        chk("run_gen5", gen_count, 5);
        chk("run_stable", stable, 0);
        chk("run_in_run", state, S_RUN);
        pulse(0, 1, 0, 0);
        chk("run_stop", state, S_IDLE);

        // Generation limit
        do_load(BLINKER);
        max_gen = 16'd3;
        pulse(0, 0, 0, 1);
        wait_state(S_HALT, 100, "lim_halt");
        chk("lim_done", done, 1);
        chk("lim_gen", gen_count, 3);
        chk("lim_stable", stable, 0);
        chk("lim_busy", busy, 0);
        pulse(0, 1, 0, 0);
        chk("lim_stop", state, S_IDLE);
        chk("lim_done_clr", done, 0);

        // Block still life, single steps
        max_gen = 16'd0;
        do_load(BLOCK);
        pulse(0, 0, 1, 0);
        wait_state(S_IDLE, 10, "blk_step1");
        chk("blk_gen1", gen_count, 1);
        chk("blk_stable1", stable, 0);
        pulse(0, 0, 1, 0);
        wait_state(S_HALT, 10, "blk_halt");
        chk("blk_gen2", gen_count, 2);
        chk("blk_stable2", stable, 1);
        chk("blk_done", done, 0);
        pulse(0, 0, 0, 1);
        chk("halt_ign_start", state, S_HALT);
        pulse(0, 1, 0, 0);

        // Stop during WAIT is deferred until the sample
        do_load(BLINKER);
        pulse(0, 0, 0, 1);
        np = 0;
        while (!dp_run && np < 40) begin
            @(negedge clk);
            np++;
        end
        chk("mw_dp_run", dp_run, 1);
        chk("mw_in_wait", state, S_WAIT);
        pulse(0, 1, 0, 0);
        chk("mw_deferred", state, S_WAIT);
        chk("mw_gen0", gen_count, 0);
        @(negedge clk);
        chk("mw_idle", state, S_IDLE);
        chk("mw_gen1", gen_count, 1);
        ndp = 0;
        for (int i = 0; i < 20; i++) begin
            if (dp_run) ndp++;
            @(negedge clk);
        end
        chk("mw_no_run", ndp, 0);

        // Reset mid-RUN
        do_load(BLINKER);
        pulse(0, 0, 0, 1);
        repeat (8) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("mr_state", state, S_IDLE);
        chk("mr_gen", gen_count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_dp_run", dp_run, 0);
        reset = 1;
        @(negedge clk);

        // Same-cycle load + start: only LOAD happens
        pulse(1, 0, 0, 1);
        chk("clash_load", state, S_LOAD);
        chk("clash_dp_reset", dp_reset, 1);
        repeat (2) @(negedge clk);
        chk("clash_idle", state, S_IDLE);
        chk("clash_no_run", dp_run, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
